// File: rtl/fir_pkg.sv
// Shared types, sizes and the low-pass coefficient table for the per-channel FIR.
package fir_pkg;

  localparam int unsigned NTAPS = 32;
  localparam int unsigned DW    = 24;
  localparam int unsigned CW    = 16;
  localparam int unsigned ACCW  = 48;
  localparam int unsigned AW    = $clog2(NTAPS);
  localparam int unsigned FRAC  = CW - 1;

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [CW-1:0]   coef_t;
  typedef logic signed [ACCW-1:0] acc_t;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, ROUND = 2'd2} state_e;

  // Hamming-windowed sinc, fc ~4 kHz at 48 kHz; symmetric, sums to 32768 (unity DC gain)
  localparam coef_t H [NTAPS] = '{
      16'sd52,   16'sd62,   16'sd64,   16'sd35,  -16'sd52,  -16'sd207, -16'sd402, -16'sd556,
     -16'sd552, -16'sd271,  16'sd364,  16'sd1343, 16'sd2551, 16'sd3786, 16'sd4799, 16'sd5368,
      16'sd5368, 16'sd4799, 16'sd3786, 16'sd2551, 16'sd1343, 16'sd364, -16'sd271, -16'sd552,
     -16'sd556, -16'sd402, -16'sd207,  -16'sd52,  16'sd35,   16'sd64,   16'sd62,   16'sd52
  };

  localparam acc_t RND_HALF = acc_t'(2 ** (FRAC - 1));
  localparam acc_t SAT_MAX  = acc_t'(2 ** (DW - 1) - 1);
  localparam acc_t SAT_MIN  = -SAT_MAX - acc_t'(1);

  // Drop the Q1.15 coefficient scaling with round-half-up, then clamp to the sample range
  function automatic sample_t round_sat(input acc_t acc);
    acc_t r;
    r = (acc + RND_HALF) >>> FRAC;
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return DW'(r);
  endfunction

endpackage

// File: rtl/fir_if.sv
// Sample-in / filtered-sample-out handshake between mixer, filter and I2S transmit path.
interface fir_if;
  import fir_pkg::*;

  logic    i_valid;
  sample_t i_data;
  sample_t o_data;
  logic    o_valid;
  logic    busy;
  logic    overrun;

  modport master (output i_valid, i_data, input o_data, o_valid, busy, overrun);
  modport slave  (input i_valid, i_data, output o_data, o_valid, busy, overrun);

endinterface

// File: rtl/fir_mac.sv
// Single shared multiplier with a wide accumulator; clear wins over enable.
module fir_mac
  import fir_pkg::*;
(
  input  logic    mclk,
  input  logic    reset,
  input  logic    clr_i,
  input  logic    en_i,
  input  sample_t x_i,
  input  coef_t   h_i,
  output acc_t    acc_o
);

  logic signed [DW+CW-1:0] prod_c;
  acc_t acc_q, acc_d;

  always_comb begin
    prod_c = x_i * h_i;
    acc_d  = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACCW'(prod_c);
  end

  always_ff @(posedge mclk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_lpf.sv
// Time-multiplexed 32-tap low-pass FIR: circular history, serial MAC, round/saturate.
module fir_lpf
  import fir_pkg::*;
(
  input  logic mclk,
  input  logic reset,
  fir_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_MAC   = 2'(MAC);
  localparam logic [1:0] S_ROUND = 2'(ROUND);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, k_q, k_d, rd_idx_c;
  sample_t       hist_q [NTAPS];
  sample_t       o_data_q, o_data_d;
  logic          o_valid_q, o_valid_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          wr_en_c, clr_c, en_c;
  acc_t          acc_c;

  fir_mac u_mac (
    .mclk  (mclk),
    .reset (reset),
    .clr_i (clr_c),
    .en_i  (en_c),
    .x_i   (hist_q[rd_idx_c]),
    .h_i   (H[k_q]),
    .acc_o (acc_c)
  );

  // Newest sample sits at wp; tap k reads k samples back, wrapping naturally
  assign rd_idx_c = wp_q - k_q;

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    k_d       = k_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    wr_en_c   = 1'b0;
    clr_c     = 1'b0;
    en_c      = 1'b0;
    overrun_d = bus.i_valid && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          wr_en_c = 1'b1;
          wp_d    = wp_q + AW'(1);
          k_d     = '0;
          clr_c   = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        en_c = 1'b1;
        k_d  = k_q + AW'(1);
        if (k_q == AW'(NTAPS - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        o_data_d  = round_sat(acc_c);
        o_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      k_q       <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      k_q       <= k_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      foreach (hist_q[i]) hist_q[i] <= '0;
    end else if (wr_en_c) begin
      hist_q[wp_d] <= bus.i_data;
    end
  end

  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_fir_lpf.sv
// Randomized bench for fir_lpf against a direct-convolution model with per-cycle checks.
module tb_fir_lpf;
  import fir_pkg::*;

  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  fir_if bus ();

  fir_lpf dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: newest-first sample list, output = rounded/saturated dot product with H
  longint  mh [NTAPS];
  bit      m_live = 1'b0;
  bit      m_inflight = 1'b0;
  int      m_acc_cyc = 0;
  longint  m_y = 0;
  logic    e_valid, e_ovr, e_busy;
  sample_t e_data;

  function automatic longint ref_out();
    longint s;
    s = 0;
    for (int k = 0; k < int'(NTAPS); k++) s += mh[k] * longint'(H[k]);
    s = (s + 64'sd16384) >>> 15;
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return s;
  endfunction

  always @(posedge mclk) begin
    bit was_busy;
    cyc++;
    if (reset !== 1'b1) begin
      foreach (mh[i]) mh[i] = 0;
      m_inflight = 1'b0;
      e_valid = 1'b0;
      e_ovr   = 1'b0;
      e_busy  = 1'b0;
      e_data  = '0;
      m_live  = 1'b1;
    end else if (m_live) begin
      was_busy = m_inflight;
      e_valid  = 1'b0;
      if (m_inflight && cyc == m_acc_cyc + int'(NTAPS) + 1) begin
        e_valid    = 1'b1;
        e_data     = sample_t'(m_y);
        m_inflight = 1'b0;
      end
      e_ovr = bus.i_valid && was_busy;
      if (bus.i_valid && !was_busy) begin
        for (int i = int'(NTAPS) - 1; i > 0; i--) mh[i] = mh[i-1];
        mh[0]      = longint'(bus.i_data);
        m_y        = ref_out();
        m_inflight = 1'b1;
        m_acc_cyc  = cyc;
      end
      e_busy = m_inflight;
    end
  end

  int      n_out = 0;
  int      n_ovr = 0;
  int      last_out_cyc = 0;
  sample_t last_out = '0;

  always @(negedge mclk) begin
    if (m_live) begin
      chk("o_valid", 32'(bus.o_valid), 32'(e_valid));
      chk("overrun", 32'(bus.overrun), 32'(e_ovr));
      chk("busy",    32'(bus.busy),    32'(e_busy));
      chk("o_data",  32'(bus.o_data),  32'(e_data));
      if (bus.o_valid === 1'b1) begin
        n_out++;
        last_out     = bus.o_data;
        last_out_cyc = cyc;
      end
      if (bus.overrun === 1'b1) n_ovr++;
    end
  end

  int send_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic send(input sample_t d, input int gap);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    send_cyc    = cyc + 1;
    tick(1);
    bus.i_valid = 1'b0;
    bus.i_data  = sample_t'($urandom);
    if (gap > 1) tick(gap - 1);
  endtask

  initial begin
    int hsum, habs, asym, base_out, base_ovr, s0;
    reset       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;

    // Coefficient table properties
    hsum = 0; habs = 0; asym = 0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      hsum += int'(H[i]);
      habs += (H[i] < 0) ? -int'(H[i]) : int'(H[i]);
      if (H[i] != H[int'(NTAPS) - 1 - i]) asym++;
    end
    chk("h_sum", 32'(hsum), 32'd32768);
    chk("h_symmetric", 32'(asym), 32'd0);
    chk("h_side_lobes", 32'(habs > 32768), 32'd1);

    tick(3);
    chk("rst_o_data",  32'(bus.o_data),  32'd0);
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b1;
    tick(2);

    // Abort a computation at the 10th MAC cycle
    base_out = n_out;
    send(sample_t'(24'h3A5A5A), 1);
    tick(9);
    reset = 1'b0;
    tick(1);
    chk("midmac_rst_busy",   32'(bus.busy),   32'd0);
    chk("midmac_rst_o_data", 32'(bus.o_data), 32'd0);
    reset = 1'b1;
    tick(50);
    chk("midmac_no_output", 32'(n_out), 32'(base_out));

    // Impulse response and latency
    base_out = n_out;
    for (int i = 0; i < int'(NTAPS); i++) begin
      send((i == 0) ? sample_t'(24'h008000) : sample_t'(0), 40);
      chk("impulse_count", 32'(n_out), 32'(base_out + i + 1));
      chk("impulse_h", 32'(last_out), 32'(H[i]));
      chk("impulse_latency", 32'(last_out_cyc - send_cyc), 32'd33);
      if (i == 0)  chk("impulse_h0",  32'(last_out), 32'(24'sd52));
      if (i == 4)  chk("impulse_h4",  32'(last_out), 32'(-24'sd52));
      if (i == 15) chk("impulse_h15", 32'(last_out), 32'(24'sd5368));
    end

    // DC gain
    for (int i = 0; i < 40; i++) begin
      send(sample_t'(24'h100000), 35);
      if (i >= 31) chk("dc_gain", 32'(last_out), 32'(24'sh100000));
    end

    // Positive and negative saturation
    for (int n = 0; n < int'(NTAPS); n++)
      send((H[int'(NTAPS) - 1 - n] >= 0) ? sample_t'(24'h7FFFFF) : sample_t'(24'h800000), 35);
    chk("sat_pos", 32'(last_out), 32'(24'sh7FFFFF));
    for (int n = 0; n < int'(NTAPS); n++)
      send((H[int'(NTAPS) - 1 - n] >= 0) ? sample_t'(24'h800000) : sample_t'(24'h7FFFFF), 35);
    chk("sat_neg", 32'(last_out), 32'(24'sh800000));

    // Overrun: sample 5 cycles after an accepted one is dropped
    base_out = n_out;
    base_ovr = n_ovr;
    send(sample_t'($urandom), 5);
    s0 = send_cyc;
    send(sample_t'(24'h7FFFFF), 1);
    tick(40);
    chk("overrun_pulses", 32'(n_ovr), 32'(base_ovr + 1));
    chk("overrun_out_count", 32'(n_out), 32'(base_out + 1));
    chk("overrun_latency", 32'(last_out_cyc - s0), 32'd33);

    // Back-to-back at maximum rate
    base_out = n_out;
    base_ovr = n_ovr;
    for (int i = 0; i < 70; i++) send(sample_t'($urandom), 34);
    tick(40);
    chk("b2b_no_overrun", 32'(n_ovr), 32'(base_ovr));
    chk("b2b_all_out", 32'(n_out), 32'(base_out + 70));

    // Random spacing and data, including overruns
    for (int i = 0; i < 300; i++) send(sample_t'($urandom), int'($urandom_range(1, 45)));
    tick(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
